// File: rtl/tt_extractor7_pkg.sv
// Shared types and sizes for the 7-input truth-table extractor.
// Package tt7_pkg; the optional onset counter is enabled by TT_ONSET_COUNT_EN.
package tt7_pkg;

    localparam int NUM_IN       = 7;
    localparam int NUM_MINTERMS = 128;
    localparam int MAX_RESP_LAT = 7;

    typedef logic [NUM_IN-1:0]       minterm_t;
    typedef logic [NUM_MINTERMS-1:0] tt_t;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/tt_extractor7_if.sv
// Sweep/response/result bundle between the extractor and its environment.
// onset_cnt exists only when TT_ONSET_COUNT_EN is defined.
interface tt_extractor7_if;
    import tt7_pkg::*;

    logic     start;
    logic     busy;
    minterm_t stim;
    logic     resp;
    tt_t      tt;
    logic     tt_valid;
    logic     tt_ready;
`ifdef TT_ONSET_COUNT_EN
    logic [7:0] onset_cnt;

    modport master (
        input  start, resp, tt_ready,
        output busy, stim, tt, tt_valid, onset_cnt
    );
    modport slave (
        output start, resp, tt_ready,
        input  busy, stim, tt, tt_valid, onset_cnt
    );
`else
    modport master (
        input  start, resp, tt_ready,
        output busy, stim, tt, tt_valid
    );
    modport slave (
        output start, resp, tt_ready,
        input  busy, stim, tt, tt_valid
    );
`endif

endinterface

// File: rtl/tt_extractor7_cap_pipe.sv
// Delay line of (valid, minterm index) matching the function's response latency.
// DEPTH=0 is a straight pass-through for purely combinational functions.
module tt_cap_pipe
    import tt7_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_vld,
    input  minterm_t in_idx,
    output logic     out_vld,
    output minterm_t out_idx
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Clock and reset are not needed without storage.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_vld = in_vld;
            assign out_idx = in_idx;
        end else begin : g_delay
            logic     vld_reg [DEPTH];
            minterm_t idx_reg [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        vld_reg[i] <= 1'b0;
                        idx_reg[i] <= '0;
                    end
                end else begin
                    vld_reg[0] <= in_vld;
                    idx_reg[0] <= in_idx;
                    for (int i = 1; i < DEPTH; i++) begin
                        vld_reg[i] <= vld_reg[i-1];
                        idx_reg[i] <= idx_reg[i-1];
                    end
                end
            end

            assign out_vld = vld_reg[DEPTH-1];
            assign out_idx = idx_reg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/tt_extractor7.sv
// Sweeps all 128 minterms into a function-under-test and assembles its truth table.
// Define TT_ONSET_COUNT_EN to add the onset_cnt output (number of ones in tt).
module tt_extractor7
    import tt7_pkg::*;
#(
    parameter int RESP_LAT  = 0,
    parameter int START_IDX = 0
) (
    input logic             clk,
    input logic             rst,
    tt_extractor7_if.master bus
);

    localparam minterm_t   START_M   = minterm_t'(START_IDX);
    localparam logic [7:0] ISSUE_ALL = 8'(NUM_MINTERMS);
    localparam logic [6:0] CAP_LAST  = 7'(NUM_MINTERMS - 1);

    state_t     state_reg, state_next;
    minterm_t   stim_reg;
    logic [7:0] issue_cnt_reg;
    logic       issue_vld_reg;
    logic [6:0] cap_cnt_reg;
    tt_t        tt_reg;
`ifdef TT_ONSET_COUNT_EN
    logic [7:0] onset_reg;
`endif

    logic     cap_vld;
    minterm_t cap_idx;
    logic     accept;
    logic     issuing;
    logic     last_cap;

    assign accept   = (state_reg == IDLE) && bus.start;
    assign issuing  = (state_reg == SWEEP) && (issue_cnt_reg != ISSUE_ALL);
    assign last_cap = cap_vld && (cap_cnt_reg == CAP_LAST);

    tt_cap_pipe #(
        .DEPTH (RESP_LAT)
    ) u_cap_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (issue_vld_reg),
        .in_idx  (stim_reg),
        .out_vld (cap_vld),
        .out_idx (cap_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DONE is entered on the edge of the final capture, whichever state is sweeping.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (last_cap) begin
                    state_next = DONE;
                end else if (issue_cnt_reg == ISSUE_ALL) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_cap) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.tt_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The first minterm is driven on the accepting edge; 127 more follow in SWEEP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stim_reg      <= '0;
            issue_cnt_reg <= '0;
            issue_vld_reg <= 1'b0;
        end else if (accept) begin
            stim_reg      <= START_M;
            issue_cnt_reg <= 8'd1;
            issue_vld_reg <= 1'b1;
        end else if (issuing) begin
            stim_reg      <= stim_reg + 7'd1;
            issue_cnt_reg <= issue_cnt_reg + 8'd1;
            issue_vld_reg <= 1'b1;
        end else begin
            issue_vld_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_cnt_reg <= '0;
            tt_reg      <= '0;
`ifdef TT_ONSET_COUNT_EN
            onset_reg   <= '0;
`endif
        end else if (accept) begin
            cap_cnt_reg <= '0;
            tt_reg      <= '0;
`ifdef TT_ONSET_COUNT_EN
            onset_reg   <= '0;
`endif
        end else if (cap_vld) begin
            cap_cnt_reg      <= cap_cnt_reg + 7'd1;
            tt_reg[cap_idx]  <= bus.resp;
`ifdef TT_ONSET_COUNT_EN
            onset_reg        <= onset_reg + {7'd0, bus.resp};
`endif
        end
    end

    assign bus.busy     = (state_reg != IDLE);
    assign bus.tt_valid = (state_reg == DONE);
    assign bus.stim     = stim_reg;
    assign bus.tt       = tt_reg;
`ifdef TT_ONSET_COUNT_EN
    assign bus.onset_cnt = onset_reg;
`endif

endmodule

// File: tb/tb_tt_extractor7.sv
// Bench for tt_extractor7: a combinational instance (RESP_LAT=0) and a
// registered-function instance (RESP_LAT=3, START_IDX=100), scoreboard-checked.
`timescale 1ns/1ps
module tb_tt_extractor7;
    import tt7_pkg::*;

    localparam int LAT_A   = 0;
    localparam int START_A = 0;
    localparam int LAT_B   = 3;
    localparam int START_B = 100;
    localparam int MAX_WAIT = 400;

    typedef struct packed {
        logic       busy;
        logic       valid;
        minterm_t   stim;
        tt_t        tt;
        logic [7:0] onset;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_extractor7_if ifa ();
    tt_extractor7_if ifb ();

    tt_extractor7 #(.RESP_LAT(LAT_A), .START_IDX(START_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    tt_extractor7 #(.RESP_LAT(LAT_B), .START_IDX(START_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    tt_t q_a[$];
    tt_t q_b[$];
    int mode_a = 0;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic maj_net(input minterm_t x);
        logic a, b, d;
        a = maj3(x[0], x[1], x[5]);
        b = maj3(x[1], x[3], maj3(x[0], x[2], x[4]));
        d = maj3(x[2], x[6], maj3(x[0], x[4], x[5]));
        return maj3(a, b, d);
    endfunction

    function automatic logic fut(input int mode, input minterm_t x);
        case (mode)
            0:       return maj_net(x);
            1:       return x[0];
            2:       return x[6];
            3:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign ifa.resp = fut(mode_a, ifa.stim);

    // Three register stages of the same majority network.
    logic s1_a, s1_c, s1_e, s1_x1, s1_x2, s1_x3, s1_x6;
    logic s2_a, s2_b, s2_d, s3_f;
    always @(posedge clk) begin
        s1_a  <= maj3(ifb.stim[0], ifb.stim[1], ifb.stim[5]);
        s1_c  <= maj3(ifb.stim[0], ifb.stim[2], ifb.stim[4]);
        s1_e  <= maj3(ifb.stim[0], ifb.stim[4], ifb.stim[5]);
        s1_x1 <= ifb.stim[1];
        s1_x2 <= ifb.stim[2];
        s1_x3 <= ifb.stim[3];
        s1_x6 <= ifb.stim[6];
        s2_a  <= s1_a;
        s2_b  <= maj3(s1_x1, s1_x3, s1_c);
        s2_d  <= maj3(s1_x2, s1_x6, s1_e);
        s3_f  <= maj3(s2_a, s2_b, s2_d);
    end
    assign ifb.resp = s3_f;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t sample(input bit sel);
        obs_t o;
        o.onset = '0;
        if (sel) begin
            o.busy  = ifb.busy;
            o.valid = ifb.tt_valid;
            o.stim  = ifb.stim;
            o.tt    = ifb.tt;
`ifdef TT_ONSET_COUNT_EN
            o.onset = ifb.onset_cnt;
`endif
        end else begin
            o.busy  = ifa.busy;
            o.valid = ifa.tt_valid;
            o.stim  = ifa.stim;
            o.tt    = ifa.tt;
`ifdef TT_ONSET_COUNT_EN
            o.onset = ifa.onset_cnt;
`endif
        end
        return o;
    endfunction

    task automatic drive(input bit sel, input logic start, input logic ready);
        if (sel) begin
            ifb.start    = start;
            ifb.tt_ready = ready;
        end else begin
            ifa.start    = start;
            ifa.tt_ready = ready;
        end
    endtask

    // One full transaction: start, wait for tt_valid, compare against the
    // scoreboard, optionally stall in DONE, then complete the handshake.
    task automatic run_sweep(input bit sel, input int mode, input tt_t exp,
                             input int hold, input bit start_with_ready);
        int   edges;
        int   lat;
        int   first;
        obs_t o;
        tt_t  want;
        lat   = sel ? LAT_B : LAT_A;
        first = sel ? START_B : START_A;

        @(negedge clk);
        if (!sel) mode_a = mode;
        if (sel) q_b.push_back(exp);
        else     q_a.push_back(exp);
        drive(sel, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0);
        edges = 1;
        o = sample(sel);
        check_value("busy_after_start", o.busy, 1);
        check_value("first_stim", o.stim, first);

        while (!o.valid && edges < MAX_WAIT) begin
            @(posedge clk);
            #1;
            edges++;
            o = sample(sel);
        end
        check_value("done_latency", edges, 128 + lat + 1);

        want = sel ? q_b.pop_front() : q_a.pop_front();
        check_value("tt", o.tt, want);
        check_value("stim_last", o.stim, (first + 127) % 128);
`ifdef TT_ONSET_COUNT_EN
        check_value("onset_cnt", o.onset, $countones(want));
`endif
        $display("sweep dut=%s mode=%0d latency=%0d tt=%h", sel ? "B" : "A", mode, edges, o.tt);

        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            drive(sel, (c % 2) == 0, 1'b0);
            @(posedge clk);
            #1;
            o = sample(sel);
            check_value("hold_tt", o.tt, want);
            check_value("hold_valid", o.valid, 1);
            check_value("hold_busy", o.busy, 1);
        end

        @(negedge clk);
        drive(sel, start_with_ready, 1'b1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0);
        o = sample(sel);
        check_value("handshake_valid", o.valid, 0);
        check_value("handshake_busy", o.busy, 0);
        @(posedge clk);
        #1;
        o = sample(sel);
        check_value("idle_after_handshake", o.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        tt_t  e;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.tt_ready = 1'b0;
        ifb.start = 1'b0; ifb.tt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            o = sample(s[0]);
            check_value("reset_busy", o.busy, 0);
            check_value("reset_valid", o.valid, 0);
            check_value("reset_stim", o.stim, 0);
            check_value("reset_tt", o.tt, 0);
            check_value("reset_onset", o.onset, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        e = 128'hfeeeeeeafac8e880fee8eca0a8888880;
        run_sweep(1'b0, 0, e, 0, 1'b0);
        e = {32{4'ha}};
        run_sweep(1'b0, 1, e, 0, 1'b1);
        e = {{64{1'b1}}, {64{1'b0}}};
        run_sweep(1'b0, 2, e, 0, 1'b0);
        e = 128'hfeeeeeeafac8e880fee8eca0a8888880;
        run_sweep(1'b1, 0, e, 20, 1'b1);

        // Abort a sweep partway with an asynchronous reset.
        @(negedge clk);
        mode_a = 0;
        ifa.start = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        repeat (59) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        o = sample(1'b0);
        check_value("midreset_busy", o.busy, 0);
        check_value("midreset_valid", o.valid, 0);
        check_value("midreset_stim", o.stim, 0);
        check_value("midreset_tt", o.tt, 0);
        @(negedge clk);
        rst = 1'b0;

        e = '0;
        run_sweep(1'b0, 3, e, 0, 1'b0);
        e = '1;
        run_sweep(1'b0, 4, e, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
